// File: rtl/wb_unit.sv
// MiniRISC writeback stage: handshaked source select, multi-cycle load wait
// with timeout, sub-word load extraction/extension, registered RF write port.
module wb_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned RA_W        = 5,
    parameter int unsigned LINK_OFFSET = 4,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned ZERO_REG    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                sel,
    input  logic [RA_W-1:0]           dst,
    input  logic [XLEN-1:0]           alu_out,
    input  logic [XLEN-1:0]           imm,
    input  logic [XLEN-1:0]           pc_in,
    input  logic [1:0]                ld_size,
    input  logic                      ld_unsigned,
    input  logic [$clog2(XLEN/8)-1:0] addr_lo,
    input  logic                      mem_rvalid,
    input  logic [XLEN-1:0]           mem_rdata,
    input  logic                      flush,
    output logic                      rf_we,
    output logic [RA_W-1:0]           rf_waddr,
    output logic [XLEN-1:0]           rf_wdata,
    output logic                      err,
    output logic [31:0]               retire_cnt
);

    localparam int unsigned AW = $clog2(XLEN/8);
    localparam int unsigned TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_WAIT_MEM = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [RA_W-1:0] dst_q, dst_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            rf_we_q, rf_we_d;
    logic [RA_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic            err_q, err_d;
    logic [31:0]     retire_q, retire_d;

    logic [XLEN-1:0] src_data;
    logic            aligned;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_data;
    logic            fill;
    logic            accept;

    // Non-memory source mux and alignment check on the incoming operation.
    always_comb begin
        src_data = alu_out;
        case (sel)
            2'b10:   src_data = pc_in + XLEN'(LINK_OFFSET);
            2'b11:   src_data = imm;
            default: src_data = alu_out;
        endcase
        aligned = 1'b1;
        case (ld_size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr_lo[0];
            default: aligned = (addr_lo == '0);
        endcase
    end

    // Lane extraction and sign/zero extension using the latched load attributes.
    always_comb begin
        shifted   = mem_rdata >> {addr_q, 3'b000};
        fill      = 1'b0;
        load_data = shifted;
        case (size_q)
            2'b00: begin
                fill      = ~uns_q & shifted[7];
                load_data = {{(XLEN-8){fill}}, shifted[7:0]};
            end
            2'b01: begin
                fill      = ~uns_q & shifted[15];
                load_data = {{(XLEN-16){fill}}, shifted[15:0]};
            end
            default: load_data = shifted;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        dst_d      = dst_q;
        size_d     = size_q;
        uns_d      = uns_q;
        addr_d     = addr_q;
        timer_d    = timer_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        err_d      = 1'b0;
        in_ready   = (state_q == S_IDLE) && !flush;
        accept     = in_valid && in_ready;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (sel != 2'b01) begin
                        rf_we_d    = !((ZERO_REG != 0) && (dst == '0));
                        rf_waddr_d = dst;
                        rf_wdata_d = src_data;
                    end else if (!aligned) begin
                        err_d = 1'b1;
                    end else begin
                        dst_d   = dst;
                        size_d  = ld_size;
                        uns_d   = ld_unsigned;
                        addr_d  = addr_lo;
                        timer_d = '0;
                        state_d = S_WAIT_MEM;
                    end
                end
            end
            S_WAIT_MEM: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (mem_rvalid) begin
                    rf_we_d    = !((ZERO_REG != 0) && (dst_q == '0));
                    rf_waddr_d = dst_q;
                    rf_wdata_d = load_data;
                    state_d    = S_IDLE;
                end else if (timer_q == TW'(MEM_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        retire_d = rf_we_d ? (retire_q + 32'd1) : retire_q;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            dst_q      <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            timer_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
            retire_q   <= '0;
        end else begin
            state_q    <= state_d;
            dst_q      <= dst_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            addr_q     <= addr_d;
            timer_q    <= timer_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            err_q      <= err_d;
            retire_q   <= retire_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign err        = err_q;
    assign retire_cnt = retire_q;

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: expected writes/errors go into a scoreboard
// queue when stimulus is driven and are checked as the DUT emits them.
module tb_wb_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  sel;
    logic [4:0]  dst;
    logic [31:0] alu_out;
    logic [31:0] imm;
    logic [31:0] pc_in;
    logic [1:0]  ld_size;
    logic        ld_unsigned;
    logic [1:0]  addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        flush;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        err;
    logic [31:0] retire_cnt;

    typedef struct packed {
        logic        is_err;
        logic [4:0]  addr;
        logic [31:0] data;
    } evt_t;

    evt_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_retire = 32'd0;

    wb_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sel        (sel),
        .dst        (dst),
        .alu_out    (alu_out),
        .imm        (imm),
        .pc_in      (pc_in),
        .ld_size    (ld_size),
        .ld_unsigned(ld_unsigned),
        .addr_lo    (addr_lo),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .flush      (flush),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .err        (err),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
        evt_t e;
        e.is_err = 1'b0;
        e.addr   = a;
        e.data   = d;
        sb.push_back(e);
    endtask

    task automatic push_err();
        evt_t e;
        e.is_err = 1'b1;
        e.addr   = 5'd0;
        e.data   = 32'd0;
        sb.push_back(e);
    endtask

    // Drive one operation for a single cycle; returns #1 after the accepting edge.
    task automatic drive_op(input logic [1:0] s, input logic [4:0] d, input logic [31:0] a,
                            input logic [31:0] im, input logic [31:0] pc,
                            input logic [1:0] sz, input logic u, input logic [1:0] al);
        in_valid    = 1'b1;
        sel         = s;
        dst         = d;
        alu_out     = a;
        imm         = im;
        pc_in       = pc;
        ld_size     = sz;
        ld_unsigned = u;
        addr_lo     = al;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Output monitor: every rf_we/err pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (rf_we || err)) begin
            if (sb.size() == 0) begin
                check("spurious_event", 32'({rf_we, err}), 32'd0);
            end else begin
                evt_t e;
                e = sb.pop_front();
                check("event_kind_err", 32'(err), 32'(e.is_err));
                check("event_kind_we", 32'(rf_we), 32'(!e.is_err));
                if (!e.is_err) begin
                    exp_retire = exp_retire + 32'd1;
                    check("rf_waddr", 32'(rf_waddr), 32'(e.addr));
                    check("rf_wdata", rf_wdata, e.data);
                    check("retire_cnt", retire_cnt, exp_retire);
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        sel         = 2'b00;
        dst         = 5'd0;
        alu_out     = 32'd0;
        imm         = 32'd0;
        pc_in       = 32'd0;
        ld_size     = 2'b00;
        ld_unsigned = 1'b0;
        addr_lo     = 2'd0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'd0;
        flush       = 1'b0;

        // Reset state
        #1;
        check("reset_rf_we", 32'(rf_we), 32'd0);
        check("reset_rf_waddr", 32'(rf_waddr), 32'd0);
        check("reset_rf_wdata", rf_wdata, 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_retire", retire_cnt, 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU op
        push_wr(5'd3, 32'h1234_5678);
        drive_op(2'b00, 5'd3, 32'h1234_5678, 32'd0, 32'd0, 2'b00, 1'b0, 2'd0);
        check("alu_we_now", 32'(rf_we), 32'd1);
        check("alu_retire_now", retire_cnt, 32'd1);

        // LINK then IMM back to back
        push_wr(5'd1, 32'h0000_0104);
        check("ready_before_link", 32'(in_ready), 32'd1);
        drive_op(2'b10, 5'd1, 32'd0, 32'd0, 32'h0000_0100, 2'b00, 1'b0, 2'd0);
        push_wr(5'd2, 32'hFFFF_0000);
        check("ready_before_imm", 32'(in_ready), 32'd1);
        drive_op(2'b11, 5'd2, 32'd0, 32'hFFFF_0000, 32'd0, 2'b00, 1'b0, 2'd0);
        check("ready_after_imm", 32'(in_ready), 32'd1);

        // Signed byte load, data after 3 cycles
        push_wr(5'd5, 32'hFFFF_FF80);
        drive_op(2'b01, 5'd5, 32'd0, 32'd0, 32'd0, 2'b00, 1'b0, 2'd2);
        check("wait_ready0_a", 32'(in_ready), 32'd0);
        idle_cycles(2);
        check("wait_ready0_b", 32'(in_ready), 32'd0);
        mem_rdata  = 32'h0080_0000;
        mem_rvalid = 1'b1;
        idle_cycles(1);
        mem_rvalid = 1'b0;
        check("ready_after_load", 32'(in_ready), 32'd1);

        // Unsigned byte load; rvalid held in the accept cycle is ignored
        push_wr(5'd6, 32'h0000_0080);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h00FF_0000;
        drive_op(2'b01, 5'd6, 32'd0, 32'd0, 32'd0, 2'b00, 1'b1, 2'd2);
        check("no_write_accept_cycle", 32'(rf_we), 32'd0);
        mem_rdata = 32'h0080_0000;
        idle_cycles(1);
        mem_rvalid = 1'b0;

        // Signed half load at upper lane
        push_wr(5'd7, 32'hFFFF_8001);
        drive_op(2'b01, 5'd7, 32'd0, 32'd0, 32'd0, 2'b01, 1'b0, 2'd2);
        mem_rdata  = 32'h8001_1234;
        mem_rvalid = 1'b1;
        idle_cycles(1);
        mem_rvalid = 1'b0;

        // Misaligned half and full loads
        push_err();
        drive_op(2'b01, 5'd8, 32'd0, 32'd0, 32'd0, 2'b01, 1'b0, 2'd1);
        check("misaligned_half_ready", 32'(in_ready), 32'd1);
        push_err();
        drive_op(2'b01, 5'd8, 32'd0, 32'd0, 32'd0, 2'b10, 1'b0, 2'd2);
        idle_cycles(1);

        // Timeout: MEM_TIMEOUT cycles in WAIT_MEM, then a late rvalid
        push_err();
        drive_op(2'b01, 5'd9, 32'd0, 32'd0, 32'd0, 2'b10, 1'b0, 2'd0);
        idle_cycles(14);
        check("timeout_still_waiting", 32'(in_ready), 32'd0);
        idle_cycles(1);
        check("timeout_back_idle", 32'(in_ready), 32'd1);
        mem_rdata  = 32'hDEAD_BEEF;
        mem_rvalid = 1'b1;
        idle_cycles(1);
        mem_rvalid = 1'b0;
        idle_cycles(1);

        // Data arriving in the timeout cycle wins
        push_wr(5'd10, 32'hCAFE_BABE);
        drive_op(2'b01, 5'd10, 32'd0, 32'd0, 32'd0, 2'b10, 1'b0, 2'd0);
        idle_cycles(14);
        mem_rdata  = 32'hCAFE_BABE;
        mem_rvalid = 1'b1;
        idle_cycles(1);
        mem_rvalid = 1'b0;
        idle_cycles(1);

        // ALU op to register 0 is suppressed
        drive_op(2'b00, 5'd0, 32'hAAAA_5555, 32'd0, 32'd0, 2'b00, 1'b0, 2'd0);
        idle_cycles(1);
        check("zero_reg_retire", retire_cnt, exp_retire);

        // Flush in IDLE blocks the accept
        flush = 1'b1;
        #1;
        check("flush_ready0", 32'(in_ready), 32'd0);
        drive_op(2'b00, 5'd11, 32'h1111_1111, 32'd0, 32'd0, 2'b00, 1'b0, 2'd0);
        flush = 1'b0;

        // Flush together with rvalid in WAIT_MEM: no write
        drive_op(2'b01, 5'd12, 32'd0, 32'd0, 32'd0, 2'b10, 1'b0, 2'd0);
        flush      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        idle_cycles(1);
        flush      = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        check("flush_back_idle", 32'(in_ready), 32'd1);
        idle_cycles(2);
        check("flush_retire", retire_cnt, exp_retire);

        // Async reset mid-WAIT_MEM
        drive_op(2'b01, 5'd13, 32'd0, 32'd0, 32'd0, 2'b10, 1'b0, 2'd0);
        idle_cycles(1);
        rst_n      = 1'b0;
        exp_retire = 32'd0;
        #1;
        check("async_rf_wdata", rf_wdata, 32'd0);
        check("async_rf_waddr", 32'(rf_waddr), 32'd0);
        check("async_retire", retire_cnt, 32'd0);
        check("async_rf_we", 32'(rf_we), 32'd0);
        check("async_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mem_rdata  = 32'h7777_7777;
        mem_rvalid = 1'b1;
        idle_cycles(1);
        mem_rvalid = 1'b0;
        idle_cycles(1);
        check("post_reset_retire", retire_cnt, 32'd0);

        // Counter restarts from zero
        push_wr(5'd14, 32'h0BAD_F00D);
        drive_op(2'b00, 5'd14, 32'h0BAD_F00D, 32'd0, 32'd0, 2'b00, 1'b0, 2'd0);
        idle_cycles(3);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
